// File: rtl/task_cmd_parser_if.sv
// Command-stream / task-issue bundle for task_cmd_parser.
// Ports (as signals of the bundle):
//   cmd_data, cmd_valid, cmd_ready       : host command word stream
//   task_id, task_addr, task_size        : head descriptor fields
//   task_valid, task_ready               : task issue handshake
//   task_complete                        : one-cycle pulse per finished task
// Modports: master = host/task-manager side, slave = parser side.
interface task_cmd_parser_if;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] task_id;
  logic [31:0] task_addr;
  logic [31:0] task_size;
  logic        task_valid;
  logic        task_ready;
  logic        task_complete;

  modport master (
    output cmd_data, cmd_valid, task_ready, task_complete,
    input  cmd_ready, task_id, task_addr, task_size, task_valid
  );

  modport slave (
    input  cmd_data, cmd_valid, task_ready, task_complete,
    output cmd_ready, task_id, task_addr, task_size, task_valid
  );
endinterface

// File: rtl/task_cmd_parser.sv
// Task command parser: assembles {id, addr, size} descriptors from a 32-bit
// command word stream, validates them, buffers valid ones in a FIFO and
// issues them on a valid/ready interface, throttled by outstanding tasks.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : command stream in, task issue out, task_complete in
//   outstanding_cnt : issued minus completed tasks
//   err_valid       : one-cycle error pulse
//   err_code        : 1=size zero, 2=addr misaligned, 3=completion underflow
//   idle            : FIFO empty, nothing outstanding, assembler waiting for id
module task_cmd_parser #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ADDR_ALIGN      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  task_cmd_parser_if.slave          bus,
  output logic [3:0]                outstanding_cnt,
  output logic                      err_valid,
  output logic [1:0]                err_code,
  output logic                      idle
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_ID, S_ADDR, S_SIZE} state_t;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] addr;
    logic [31:0] size;
  } desc_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        id_q;
  logic [31:0]        addr_q;
  desc_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               empty;
  logic               xfer;
  logic               issue;
  logic               push;
  logic               val_err;
  logic [1:0]         val_code;
  logic               underflow;
  logic               size_zero;
  logic               misaligned;
  desc_t              head;

  // FIFO status; a pop in the same cycle does not free a slot for cmd_ready
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign bus.cmd_ready = rst || (state != S_SIZE) || !full;
  assign xfer          = bus.cmd_valid && bus.cmd_ready;

  // Issue path straight from the FIFO head; fields read as zero when empty
  assign bus.task_valid = !rst && !empty && (outstanding_cnt < 4'(MAX_OUTSTANDING));
  assign issue          = bus.task_valid && bus.task_ready;
  assign head           = empty ? '0 : mem[rd_ptr];
  assign bus.task_id    = head.id;
  assign bus.task_addr  = head.addr;
  assign bus.task_size  = head.size;

  assign idle = rst || (empty && (outstanding_cnt == 4'd0) && (state == S_ID));

  // Descriptor checks on the incoming size word
  assign size_zero  = (bus.cmd_data == 32'd0);
  assign misaligned = ((addr_q & 32'(ADDR_ALIGN - 1)) != 32'd0);

  // Completion with nothing outstanding and no issue to cancel against
  assign underflow = bus.task_complete && (outstanding_cnt == 4'd0) && !issue;

  // Assembler state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ID;
    end else begin
      state <= state_nxt;
    end
  end

  // Assembler next state, push and validation result
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    val_err   = 1'b0;
    val_code  = 2'd0;
    case (state)
      S_ID:   if (xfer) state_nxt = S_ADDR;
      S_ADDR: if (xfer) state_nxt = S_SIZE;
      S_SIZE: begin
        if (xfer) begin
          state_nxt = S_ID;
          if (size_zero) begin
            val_err  = 1'b1;
            val_code = 2'd1;
          end else if (misaligned) begin
            val_err  = 1'b1;
            val_code = 2'd2;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_nxt = S_ID;
    endcase
  end

  // Capture of id and addr words
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q   <= '0;
      addr_q <= '0;
    end else begin
      if (xfer && (state == S_ID))   id_q   <= bus.cmd_data;
      if (xfer && (state == S_ADDR)) addr_q <= bus.cmd_data;
    end
  end

  // FIFO storage (no reset needed; occupancy is tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{id: id_q, addr: addr_q, size: bus.cmd_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Outstanding tracking; issue+complete in one cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_cnt <= 4'd0;
    end else if (issue && !bus.task_complete) begin
      outstanding_cnt <= outstanding_cnt + 4'd1;
    end else if (!issue && bus.task_complete && (outstanding_cnt != 4'd0)) begin
      outstanding_cnt <= outstanding_cnt - 4'd1;
    end
  end

  // Error reporting; a validation error outranks a coincident underflow
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err_valid <= val_err || underflow;
      if (val_err) begin
        err_code <= val_code;
      end else if (underflow) begin
        err_code <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_task_cmd_parser.sv
// Self-checking bench for task_cmd_parser: a cycle-level reference model with
// an expected-descriptor queue (scoreboard) checked on every falling edge,
// a table of descriptors with their expected validation codes, and scripted
// backpressure / throttle / underflow / mid-operation reset sequences.
module tb_task_cmd_parser;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned ALIGN = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] outstanding_cnt;
  logic       err_valid;
  logic [1:0] err_code;
  logic       idle;

  always #5 clk = ~clk;

  task_cmd_parser_if bus();

  task_cmd_parser #(
    .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .ADDR_ALIGN(ALIGN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .outstanding_cnt(outstanding_cnt),
    .err_valid(err_valid),
    .err_code(err_code),
    .idle(idle)
  );

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] addr;
    logic [31:0] size;
  } desc_t;

  typedef struct {
    logic [31:0] id;
    logic [31:0] addr;
    logic [31:0] size;
    logic [1:0]  code;
  } vec_t;

  desc_t       m_q[$];
  int          m_pos;
  int          m_out;
  bit          m_errv;
  logic [1:0]  m_errc;
  logic [1:0]  cur_code;
  logic [31:0] cap_id;
  logic [31:0] cap_addr;
  bit          last_xfer;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_q.delete();
    m_pos     = 0;
    m_out     = 0;
    m_errv    = 1'b0;
    m_errc    = 2'd0;
    last_xfer = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, return #1 after the rising edge
  task automatic tick();
    bit    exp_rdy;
    bit    exp_tv;
    bit    exp_idle;
    bit    xfer;
    bit    issue;
    bit    verr;
    bit    uf;
    desc_t d;
    @(negedge clk);
    exp_rdy  = rst || (m_pos != 2) || (m_q.size() < DEPTH);
    exp_tv   = !rst && (m_q.size() > 0) && (m_out < MAXO);
    exp_idle = rst || ((m_q.size() == 0) && (m_out == 0) && (m_pos == 0));
    d        = (m_q.size() > 0) ? m_q[0] : '0;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_rdy));
    chk("task_valid", 32'(bus.task_valid), 32'(exp_tv));
    chk("task_id", bus.task_id, d.id);
    chk("task_addr", bus.task_addr, d.addr);
    chk("task_size", bus.task_size, d.size);
    chk("outstanding_cnt", 32'(outstanding_cnt), 32'(m_out));
    chk("err_valid", 32'(err_valid), 32'(m_errv));
    chk("err_code", 32'(err_code), 32'(m_errc));
    chk("idle", 32'(idle), 32'(exp_idle));
    if (rst) begin
      reset_model();
    end else begin
      xfer  = bus.cmd_valid && exp_rdy;
      issue = exp_tv && bus.task_ready;
      verr  = 1'b0;
      if (issue) void'(m_q.pop_front());
      if (xfer) begin
        case (m_pos)
          0: cap_id = bus.cmd_data;
          1: cap_addr = bus.cmd_data;
          default: begin
            if (cur_code == 2'd0) m_q.push_back('{id: cap_id, addr: cap_addr, size: bus.cmd_data});
            else verr = 1'b1;
          end
        endcase
        m_pos = (m_pos + 1) % 3;
      end
      uf = bus.task_complete && (m_out == 0) && !issue;
      if (issue && !bus.task_complete) m_out++;
      else if (!issue && bus.task_complete && (m_out > 0)) m_out--;
      m_errv = verr || uf;
      if (verr) m_errc = cur_code;
      else if (uf) m_errc = 2'd3;
      last_xfer = xfer;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last_xfer && n < 200);
    if (!last_xfer) begin
      checks++;
      errors++;
      $display("FAIL %s: word not accepted within 200 cycles", name);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bus.cmd_data  = w;
    bus.cmd_valid = 1'b1;
    wait_xfer("cmd_word_timeout");
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_desc(input vec_t v);
    cur_code = v.code;
    send_word(v.id);
    send_word(v.addr);
    send_word(v.size);
  endtask

  task automatic retire_all();
    int n = 0;
    while (m_out > 0 && n < 20) begin
      bus.task_complete = 1'b1;
      tick();
      n++;
    end
    bus.task_complete = 1'b0;
    chk("retire_all", 32'(outstanding_cnt), 32'd0);
  endtask

  vec_t tab[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    tab[0] = '{32'h11, 32'h1000, 32'h80,       2'd0};
    tab[1] = '{32'h1,  32'h1000, 32'h0,        2'd1};
    tab[2] = '{32'h2,  32'h1004, 32'h40,       2'd2};
    tab[3] = '{32'h3,  32'h1001, 32'h0,        2'd1};
    tab[4] = '{32'h4,  32'h2040, 32'h10,       2'd0};
    tab[5] = '{32'h5,  32'h3fc0, 32'hffffffff, 2'd0};
    tab[6] = '{32'h6,  32'h20,   32'h8,        2'd2};

    rst               = 1'b1;
    bus.cmd_data      = '0;
    bus.cmd_valid     = 1'b0;
    bus.task_ready    = 1'b0;
    bus.task_complete = 1'b0;
    cur_code          = 2'd0;
    cap_id            = '0;
    cap_addr          = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_outstanding", 32'(outstanding_cnt), 32'd0);

    // Table: basic descriptor, validation errors, alignment of the assembler
    bus.task_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_desc(tab[i]);
      chk("size_to_valid", 32'(bus.task_valid), 32'(tab[i].code == 2'd0));
      tick();
      if (tab[i].code == 2'd0) begin
        chk("issued_cnt", 32'(outstanding_cnt), 32'd1);
        bus.task_complete = 1'b1;
        tick();
        bus.task_complete = 1'b0;
      end else begin
        chk("err_code_tab", 32'(err_code), 32'(tab[i].code));
      end
      tick();
      chk("idle_after", 32'(idle), 32'd1);
    end

    // Backpressure: five descriptors against a four-entry FIFO
    bus.task_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = '{32'h100 + 32'(i), 32'h40 * 32'(i + 1), 32'(i + 1), 2'd0};
      send_desc(v);
    end
    cur_code = 2'd0;
    send_word(32'h104);
    send_word(32'h140);
    bus.cmd_data  = 32'h5;
    bus.cmd_valid = 1'b1;
    repeat (3) tick();
    chk("cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
    chk("stalled_head_id", bus.task_id, 32'h100);
    bus.task_ready = 1'b1;
    n = 0;
    do begin
      bus.task_complete = (m_out == MAXO);
      tick();
      n++;
    end while (!last_xfer && n < 50);
    if (!last_xfer) begin
      checks++;
      errors++;
      $display("FAIL fifth_size_word: not accepted after draining");
    end
    bus.cmd_valid = 1'b0;
    n = 0;
    while (m_q.size() > 0 && n < 100) begin
      bus.task_complete = (m_out == MAXO);
      tick();
      n++;
    end
    bus.task_complete = 1'b0;
    chk("drain_empty", 32'(bus.task_valid), 32'd0);
    retire_all();

    // Throttle at two outstanding
    for (int i = 0; i < 4; i++) begin
      v = '{32'h200 + 32'(i), 32'h1000 * 32'(i + 1), 32'h10, 2'd0};
      send_desc(v);
    end
    tick();
    tick();
    chk("throttle_valid", 32'(bus.task_valid), 32'd0);
    chk("throttle_cnt", 32'(outstanding_cnt), 32'd2);
    bus.task_complete = 1'b1;
    tick();
    chk("throttle_after_cpl", 32'(outstanding_cnt), 32'd1);
    chk("third_offered", bus.task_id, 32'h202);
    tick();
    bus.task_complete = 1'b0;
    chk("issue_and_cpl", 32'(outstanding_cnt), 32'd1);
    tick();
    chk("fourth_issued", 32'(outstanding_cnt), 32'd2);
    retire_all();

    // Completion underflow
    bus.task_complete = 1'b1;
    tick();
    bus.task_complete = 1'b0;
    chk("uf_err_valid", 32'(err_valid), 32'd1);
    chk("uf_err_code", 32'(err_code), 32'd3);
    chk("uf_cnt", 32'(outstanding_cnt), 32'd0);
    tick();
    chk("uf_pulse_end", 32'(err_valid), 32'd0);

    // Mid-operation reset with tasks outstanding and queued
    send_desc('{32'h300, 32'h8000, 32'h20, 2'd0});
    tick();
    bus.task_ready = 1'b0;
    send_desc('{32'h301, 32'h8040, 32'h20, 2'd0});
    send_desc('{32'h302, 32'h8080, 32'h20, 2'd0});
    send_word(32'h303);
    send_word(32'h80c0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_task_valid", 32'(bus.task_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding_cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    bus.task_ready = 1'b1;
    send_desc('{32'h77, 32'h4000, 32'h100, 2'd0});
    chk("fresh_valid", 32'(bus.task_valid), 32'd1);
    chk("fresh_id", bus.task_id, 32'h77);
    tick();
    retire_all();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/task_cmd_parser.md
Name: task_cmd_parser

Overview:
- Upstream feeder for the task manager.
- Receives a host command stream of 32-bit words. Every three words form one task descriptor: id, addr, size.
- Validates each descriptor, buffers valid ones in a small FIFO and issues them on a valid/ready task interface.
- Tracks outstanding tasks via the task manager's task_complete pulse and throttles issue at a programmable limit.

Parameters:
- FIFO_DEPTH, 4, descriptor FIFO entries (power of 2, ≥2)
- MAX_OUTSTANDING, 8, max issued-but-not-completed tasks (1..15)
- ADDR_ALIGN, 64, required byte alignment of task_addr (power of 2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- cmd_data  in  32  command word
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  parser can accept a word
- task_id  out  32  head descriptor id
- task_addr  out  32  head descriptor address
- task_size  out  32  head descriptor byte size
- task_valid  out  1  head descriptor offered downstream
- task_ready  in  1  downstream accepts
- task_complete  in  1  one-cycle pulse per finished task
- outstanding_cnt  out  4  issued minus completed
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  1=size zero, 2=addr misaligned, 3=completion underflow
- idle  out  1  FIFO empty, outstanding 0, assembler in S_ID

Behaviour:
- Reset (rst=1 at an edge) forces the following, regardless of any in-flight activity:
  - FSM to S_ID; FIFO pointers and count to 0.
  - outstanding_cnt=0, err_valid=0, err_code=0.
  - Partial descriptor discarded.
- Values while rst is held: cmd_ready=1, task_valid=0, idle=1.
- Word transfer: occurs when cmd_valid && cmd_ready at an edge.
- Assembler FSM:
  - S_ID: capture id -> S_ADDR.
  - S_ADDR: capture addr -> S_SIZE.
  - S_SIZE: evaluate descriptor -> S_ID.
- cmd_ready:
  - 1 in S_ID and S_ADDR.
  - In S_SIZE, 1 only when FIFO not full. Entries popped in the same cycle are not counted as free.
- Validation, applied in S_SIZE on the transfer edge:
  - size==0 -> drop, err_valid=1, err_code=1.
  - Otherwise addr & (ADDR_ALIGN-1) != 0 -> drop, err_code=2.
  - Otherwise push {id,addr,size}.
  - A dropped descriptor is never pushed. The FSM still returns to S_ID.
- err_code holds its last value; err_valid is high for exactly one cycle per error.
- Issue:
  - task_valid = FIFO not empty && outstanding_cnt < MAX_OUTSTANDING.
  - task_id/addr/size are driven from the FIFO head and are 0 when the FIFO is empty.
  - Pop and outstanding_cnt+1 on task_valid && task_ready.
  - Once asserted, task_valid stays asserted and the fields stay stable until accepted. This is guaranteed because outstanding only rises by issuing.
- Latency: a descriptor whose size word transfers at edge N appears with task_valid=1 after edge N, provided the throttle allows. This is 1 cycle and there is no bypass.
- FIFO: circular, pointer wrap at FIFO_DEPTH. Push and pop in the same cycle is legal and leaves the count unchanged.
- Completion:
  - task_complete decrements outstanding_cnt.
  - Issue and complete in the same cycle leave it unchanged.
  - task_complete while outstanding_cnt==0 with no simultaneous issue: count stays 0, err_valid=1, err_code=3.
  - If an underflow coincides with a validation error, the validation error code wins and the underflow is not separately reported.
- outstanding_cnt saturates logically at MAX_OUTSTANDING through the throttle and never exceeds it.
- idle is combinational from registered state.

Test Plan:
- Basic: feed words 0x11, 0x1000, 0x80 back-to-back with task_ready=1 -> task_valid one cycle after the size word, fields 0x11/0x1000/0x80, outstanding_cnt=1; pulse task_complete -> 0, idle=1.
- Errors: descriptor (0x1, 0x1000, 0) -> err_code=1 pulse, no issue. Descriptor (0x2, 0x1004, 0x40) -> err_code=2, no issue. Descriptor (0x3, 0x1001, 0) -> err_code=1. FSM stays aligned: the next good descriptor issues.
- Backpressure: task_ready=0, push 5 descriptors with FIFO_DEPTH=4 -> cmd_ready drops in S_SIZE of the 5th. Raise task_ready -> 5 tasks issue in order with stable fields while stalled.
- Throttle: MAX_OUTSTANDING=2, task_ready=1, 4 descriptors, no completes -> exactly 2 issue, task_valid stays 0 with outstanding_cnt=2. One complete -> third issues. Issue+complete in the same cycle -> count unchanged.
- Underflow: task_complete with outstanding_cnt=0 -> err_code=3 pulse, count stays 0.
- Mid-operation reset: assert rst after the addr word with 2 FIFO entries queued -> next cycle task_valid=0, outstanding_cnt=0, idle=1. A fresh 3-word descriptor issues correctly.
